ahbl_regfile: RTL and testbench

Parametrised AHB-Lite slave register file. It is the successor to the fixed three-register peripheral. It provides NUM_REGS read/write 32-bit registers plus a read-only ID word, with byte/halfword write strobes, configurable wait states and an AHB two-cycle ERROR response. It sits behind the AHB-Lite decoder/mux and exports all registers to the accelerator as a flat control bus.

---
 rtl/ahbl_regfile.sv | 164 ++++++++++++++++
 tb/tb_ahbl_regfile.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_regfile.sv
// AHB-Lite slave register file: NUM_REGS RW words, read-only ID word, byte/half strobes,
// optional wait states and two-cycle ERROR. Define AHBL_REGFILE_LOCK_EN to add the LOCK register.
module ahbl_regfile #(
    parameter int          NUM_REGS    = 4,
    parameter int          IDX_W       = 4,
    parameter int          ADDR_LSB    = 2,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID          = 32'hABCD_EF00
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [32*NUM_REGS-1:0] regs_flat
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

`ifdef AHBL_REGFILE_LOCK_EN
    localparam int MAX_IDX = NUM_REGS + 1;
`else
    localparam int MAX_IDX = NUM_REGS;
`endif

    logic [2:0]       state;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       off_q;
    logic [2:0]       size_q;
    logic             write_q;
    logic [31:0]      regs [NUM_REGS];
`ifdef AHBL_REGFILE_LOCK_EN
    logic [NUM_REGS-1:0] lock;
`endif

    logic [IDX_W-1:0] addr_idx;
    logic             accept;
    logic             legal;
    logic [3:0]       strb;
    logic             unused_addr;

    assign addr_idx    = HADDR[ADDR_LSB+IDX_W-1:ADDR_LSB];
    assign unused_addr = ^HADDR;

    // Only states that drive HREADYOUT high can see a new address phase.
    assign accept = HSEL && HTRANS[1] && HREADY &&
                    (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

    always_comb begin
        legal = 1'b1;
        if (int'(addr_idx) > MAX_IDX)                    legal = 1'b0;
        if (HWRITE && int'(addr_idx) == NUM_REGS)         legal = 1'b0;
        if (HSIZE > 3'd2)                                 legal = 1'b0;
        if (HSIZE == 3'd1 && HADDR[0])                    legal = 1'b0;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)         legal = 1'b0;
`ifdef AHBL_REGFILE_LOCK_EN
        for (int i = 0; i < NUM_REGS; i++) begin
            if (HWRITE && int'(addr_idx) == i && lock[i]) legal = 1'b0;
        end
`endif
    end

    always_comb begin
        strb = 4'b0000;
        case (size_q)
            3'd0:    strb[off_q] = 1'b1;
            3'd1:    strb = off_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            off_q    <= 2'b00;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
`ifdef AHBL_REGFILE_LOCK_EN
            lock     <= '0;
`endif
        end else begin
            if (accept) begin
                idx_q   <= addr_idx;
                off_q   <= HADDR[1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
                if (!legal) begin
                    state <= ST_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state <= ST_DATA;
                end else begin
                    state    <= ST_WAIT;
                    wait_cnt <= 4'(WAIT_STATES - 1);
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (wait_cnt == 4'd0) state <= ST_DATA;
                        else                  wait_cnt <= wait_cnt - 4'd1;
                    end
                    ST_ERR1: state <= ST_ERR2;
                    default: state <= ST_IDLE;
                endcase
            end

            // Write data is only valid in the final data-phase cycle.
            if (state == ST_DATA && write_q) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (int'(idx_q) == i) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb[b]) regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
                        end
                    end
                end
`ifdef AHBL_REGFILE_LOCK_EN
                if (int'(idx_q) == NUM_REGS + 1) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (HWDATA[i] && strb[i/8]) lock[i] <= 1'b1;
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if ((state == ST_WAIT || state == ST_DATA) && !write_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(idx_q) == i) HRDATA = regs[i];
            end
            if (int'(idx_q) == NUM_REGS) HRDATA = ID;
`ifdef AHBL_REGFILE_LOCK_EN
            if (int'(idx_q) == NUM_REGS + 1) HRDATA[NUM_REGS-1:0] = lock;
`endif
        end
    end

    assign HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2);

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[32*g +: 32] = regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_ahbl_regfile.sv
// Directed bench for ahbl_regfile: three instances (0, 3 and 2 wait states) share one bus.
module tb_ahbl_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    int          which;

    logic         ro0, ro3, ro2, rs0, rs3, rs2;
    logic [31:0]  rd0, rd3, rd2;
    logic [127:0] rf0, rf3, rf2;
    logic         hready, sel0, sel3, sel2;

    assign sel0   = hsel && (which == 0);
    assign sel3   = hsel && (which == 3);
    assign sel2   = hsel && (which == 2);
    assign hready = (which == 3) ? ro3 : (which == 2) ? ro2 : ro0;

    ahbl_regfile #(.WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0), .regs_flat(rf0));
    ahbl_regfile #(.WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3), .regs_flat(rf3));
    ahbl_regfile #(.WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2), .regs_flat(rf2));

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int idx, input logic [1:0] off);
        return (32'(idx) << 2) | {30'd0, off};
    endfunction

    // Called at #1 after a posedge; returns at #1 after the posedge closing the data phase.
    task automatic xfer(input int d, input logic w, input int idx, input logic [1:0] off,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic r1, output logic r2,
                        output int waits);
        which  = d;
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = mk_addr(idx, off);
        hwrite = w;
        hsize  = sz;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        waits  = 0;
        r1     = (d == 3) ? rs3 : (d == 2) ? rs2 : rs0;
        while (hready == 1'b0 && waits < 40) begin
            waits++;
            @(posedge clk); #1;
        end
        rd = (d == 3) ? rd3 : (d == 2) ? rd2 : rd0;
        r2 = (d == 3) ? rs3 : (d == 2) ? rs2 : rs0;
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input int d, input logic w, input int idx,
                       input logic [1:0] off, input logic [2:0] sz, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic err, input int ws);
        logic [31:0] rd;
        logic        r1, r2;
        int          waits;
        xfer(d, w, idx, off, sz, wd, rd, r1, r2, waits);
        check({nm, "_rdata"}, 128'(rd), 128'(exp_rd));
        check({nm, "_resp1"}, 128'(r1), 128'(err));
        check({nm, "_resp2"}, 128'(r2), 128'(err));
        check({nm, "_waits"}, 128'(waits), 128'(err ? 1 : ws));
    endtask

    typedef struct {
        logic        w;
        int          idx;
        logic [1:0]  off;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        err;
    } vec_t;

    vec_t vt[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b0, 0, 2'd0, 3'd2, 32'h0,          32'h0,          1'b0};
        vt[1]  = '{1'b0, 1, 2'd0, 3'd2, 32'h0,          32'h0,          1'b0};
        vt[2]  = '{1'b0, 2, 2'd0, 3'd2, 32'h0,          32'h0,          1'b0};
        vt[3]  = '{1'b0, 3, 2'd0, 3'd2, 32'h0,          32'h0,          1'b0};
        vt[4]  = '{1'b0, 4, 2'd0, 3'd2, 32'h0,          32'hABCD_EF00,  1'b0};
        vt[5]  = '{1'b1, 1, 2'd2, 3'd1, 32'h1234_0000,  32'h0,          1'b0};
        vt[6]  = '{1'b1, 1, 2'd0, 3'd0, 32'h0000_00CD,  32'h0,          1'b0};
        vt[7]  = '{1'b0, 1, 2'd0, 3'd2, 32'h0,          32'h1234_00CD,  1'b0};
        vt[8]  = '{1'b1, 4, 2'd0, 3'd2, 32'hFFFF_FFFF,  32'h0,          1'b1};
        vt[9]  = '{1'b0, 9, 2'd0, 3'd2, 32'h0,          32'h0,          1'b1};
        vt[10] = '{1'b0, 0, 2'd0, 3'd3, 32'h0,          32'h0,          1'b1};
        vt[11] = '{1'b1, 3, 2'd1, 3'd1, 32'h0000_FFFF,  32'h0,          1'b1};
        vt[12] = '{1'b1, 3, 2'd2, 3'd2, 32'hFFFF_FFFF,  32'h0,          1'b1};
        vt[13] = '{1'b0, 3, 2'd0, 3'd2, 32'h0,          32'h0,          1'b0};
        vt[14] = '{1'b0, 4, 2'd0, 3'd2, 32'h0,          32'hABCD_EF00,  1'b0};
`ifdef AHBL_REGFILE_LOCK_EN
        vt[15] = '{1'b0, 5, 2'd0, 3'd2, 32'h0,          32'h0,          1'b0};
`else
        vt[15] = '{1'b0, 5, 2'd0, 3'd2, 32'h0,          32'h0,          1'b1};
`endif
        vt[16] = '{1'b1, 0, 2'd3, 3'd0, 32'hA500_0000,  32'h0,          1'b0};

        rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0;
        hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0; which = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_readyout", 128'({ro0, ro3, ro2}), 128'(3'b111));
        check("rst_resp",     128'({rs0, rs3, rs2}), 128'(3'b000));
        check("rst_rdata",    128'(rd0 | rd3 | rd2), 128'(0));
        check("rst_flat",     rf0 | rf3 | rf2,       128'(0));

        for (int i = 0; i < 17; i++) begin
            run($sformatf("vec%0d", i), 0, vt[i].w, vt[i].idx, vt[i].off, vt[i].sz,
                vt[i].wd, vt[i].exp_rd, vt[i].err, 0);
        end
        check("flat_after_vec", rf0,
              {32'h0, 32'h0, 32'h1234_00CD, 32'hA500_0000});

        // Word write, then byte write pipelined into a word read of the same register.
        run("b2b_word", 0, 1'b1, 2, 2'd0, 3'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        which = 0; hsel = 1'b1; htrans = 2'b10;
        haddr = mk_addr(2, 2'd1); hwrite = 1'b1; hsize = 3'd0;
        @(posedge clk); #1;
        hwdata = 32'h0000_5500;
        haddr = mk_addr(2, 2'd0); hwrite = 1'b0; hsize = 3'd2;
        check("b2b_wr_ready", 128'(ro0), 128'(1));
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        check("b2b_rd_ready", 128'(ro0), 128'(1));
        check("b2b_rd_resp",  128'(rs0), 128'(0));
        check("b2b_rd_data",  128'(rd0), 128'(32'hDEAD_55EF));
        check("b2b_flat",     128'(rf0[95:64]), 128'(32'hDEAD_55EF));
        @(posedge clk); #1;

`ifdef AHBL_REGFILE_LOCK_EN
        run("lock_set",   0, 1'b1, 5, 2'd0, 3'd2, 32'h0000_0001, 32'h0, 1'b0, 0);
        run("lock_wr0",   0, 1'b1, 0, 2'd0, 3'd2, 32'h1234_5678, 32'h0, 1'b1, 0);
        run("lock_rd0",   0, 1'b0, 0, 2'd0, 3'd2, 32'h0, 32'hA500_0000, 1'b0, 0);
        run("lock_wr1",   0, 1'b1, 1, 2'd0, 3'd2, 32'h1111_1111, 32'h0, 1'b0, 0);
        run("lock_rd",    0, 1'b0, 5, 2'd0, 3'd2, 32'h0, 32'h0000_0001, 1'b0, 0);
`else
        run("nolock_wr5", 0, 1'b1, 5, 2'd0, 3'd2, 32'h0000_0001, 32'h0, 1'b1, 0);
        check("nolock_flat0", 128'(rf0[31:0]), 128'(32'hA500_0000));
`endif

        run("ws3_read_id",  3, 1'b0, 4, 2'd0, 3'd2, 32'h0, 32'hABCD_EF00, 1'b0, 3);
        run("ws3_write",    3, 1'b1, 3, 2'd0, 3'd2, 32'h0BAD_F00D, 32'h0, 1'b0, 3);
        run("ws3_read",     3, 1'b0, 3, 2'd0, 3'd2, 32'h0, 32'h0BAD_F00D, 1'b0, 3);

        // Reset asserted during the second wait cycle of a 2-wait write.
        which = 2; hsel = 1'b1; htrans = 2'b10;
        haddr = mk_addr(1, 2'd0); hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
        check("rstmid_wait1", 128'(ro2), 128'(0));
        @(posedge clk); #1;
        check("rstmid_wait2", 128'(ro2), 128'(0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstmid_ready", 128'(ro2), 128'(1));
        check("rstmid_resp",  128'(rs2), 128'(0));
        check("rstmid_rdata", 128'(rd2), 128'(0));
        check("rstmid_flat",  rf2, 128'(0));
        @(posedge clk); #1;
        check("rstmid_flat_late", rf2, 128'(0));
        run("rstmid_read", 2, 1'b0, 1, 2'd0, 3'd2, 32'h0, 32'h0, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
